game_round_ctrl: RTL



---
 rtl/game_round_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/game_round_ctrl.sv
// Round sequencer for the switch-matching game: target latch, scoring, BCD seconds timer.
// Optional: define GAME_MISS_PENALTY_EN to take one point off the score for each missed round.
module game_round_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned ROUND_SECONDS = 60
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       start,
    input  logic       submit,
    input  logic [2:0] rand1,
    input  logic [2:0] rand2,
    input  logic [2:0] rand3,
    input  logic [5:0] guess,
    output logic       rand_en,
    output logic [5:0] target,
    output logic [2:0] match,
    output logic [7:0] score,
    output logic [3:0] time_ones,
    output logic [3:0] time_tens,
    output logic       round_active,
    output logic       game_over
);

    localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_RELOAD = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]    END_ONES   = 4'(ROUND_SECONDS % 10);
    localparam logic [3:0]    END_TENS   = 4'(ROUND_SECONDS / 10);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT_IN = 3'd2,
        S_CHECK   = 3'd3,
        S_NEXT    = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic          start_q, submit_q;
    logic [5:0]    target_q, target_d;
    logic [2:0]    match_q, match_d;
    logic [7:0]    score_q, score_d;
    logic [3:0]    ones_q, ones_d, tens_q, tens_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          rand_en_q, rand_en_d;
    logic          active_q, active_d;
    logic          over_q, over_d;

    logic          start_edge, submit_edge, in_round, tick, timeout;
    logic [2:0]    hit;

    function automatic logic [1:0] mod3(input logic [2:0] v);
        return 2'(v % 3'd3);
    endfunction

    assign start_edge  = start & ~start_q;
    assign submit_edge = submit & ~submit_q;
    assign in_round    = (state_q == S_LOAD) || (state_q == S_WAIT_IN) ||
                         (state_q == S_CHECK) || (state_q == S_NEXT);
    assign tick        = in_round && (pre_q == '0);
    assign hit         = {guess[5:4] == target_q[5:4],
                          guess[3:2] == target_q[3:2],
                          guess[1:0] == target_q[1:0]};

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            submit_q  <= 1'b0;
            target_q  <= '0;
            match_q   <= '0;
            score_q   <= '0;
            ones_q    <= '0;
            tens_q    <= '0;
            pre_q     <= PRE_RELOAD;
            rand_en_q <= 1'b1;
            active_q  <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            submit_q  <= submit;
            target_q  <= target_d;
            match_q   <= match_d;
            score_q   <= score_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            pre_q     <= pre_d;
            rand_en_q <= rand_en_d;
            active_q  <= active_d;
            over_q    <= over_d;
        end
    end

    // Next-state, timer and scoring logic
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        match_d  = match_q;
        score_d  = score_q;
        ones_d   = ones_q;
        tens_d   = tens_q;
        pre_d    = pre_q;
        timeout  = 1'b0;

        if (in_round) begin
            pre_d = tick ? PRE_RELOAD : pre_q - PW'(1);
        end
        if (tick) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
            timeout = (ones_d == END_ONES) && (tens_d == END_TENS);
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_edge) begin
                    score_d = '0;
                    ones_d  = '0;
                    tens_d  = '0;
                    match_d = '0;
                    pre_d   = PRE_RELOAD;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                target_d = {mod3(rand1), mod3(rand2), mod3(rand3)};
                state_d  = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                if (submit_edge) state_d = S_CHECK;
            end
            S_CHECK: begin
                match_d = hit;
                if (hit == 3'b111) begin
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                end else begin
`ifdef GAME_MISS_PENALTY_EN
                    if (score_q != 8'h00) score_d = score_q - 8'd1;
`else
                    score_d = score_q;
`endif
                end
                state_d = S_NEXT;
            end
            S_NEXT:  state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase

        // Expiry overrides any pending transition; CHECK's score update still lands
        if (timeout) state_d = S_DONE;

        rand_en_d = (state_d == S_IDLE) || (state_d == S_NEXT) || (state_d == S_DONE);
        active_d  = (state_d == S_LOAD) || (state_d == S_WAIT_IN) ||
                    (state_d == S_CHECK) || (state_d == S_NEXT);
        over_d    = (state_d == S_DONE);
    end

    assign rand_en      = rand_en_q;
    assign target       = target_q;
    assign match        = match_q;
    assign score        = score_q;
    assign time_ones    = ones_q;
    assign time_tens    = tens_q;
    assign round_active = active_q;
    assign game_over    = over_q;

endmodule
